// File: rtl/rr_mux_arb.sv
// rr_mux_arb: registered round-robin N:1 valid/ready multiplexer with one-hot override.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_data    N channels of W bits, channel i at [i*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel accept (at most one bit set)
//   force_sel  one-hot channel override; all-zero selects round-robin
//   out_data   registered selected word
//   out_valid  out_data holds an unconsumed word
//   out_ready  downstream consumes out_data when out_valid && out_ready
//   out_grant  registered one-hot index of the channel that produced out_data
//   sel_err    sticky flag: force_sel was non-zero and not one-hot
module rr_mux_arb #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N-1:0]   force_sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_grant,
  output logic           sel_err
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_grant_q, out_grant_d;
  logic          sel_err_q, sel_err_d;
  logic [IW-1:0] last_q, last_d;

  logic          force_none;
  logic          force_bad;
  logic [N-1:0]  elig;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_onehot;
  logic [W-1:0]  win_data;
  logic          load_en;
  logic          xfer;

  // Eligible set: an illegal override blocks every channel.
  always_comb begin
    force_none = (force_sel == '0);
    force_bad  = !force_none && !$onehot(force_sel);
    if (force_none) begin
      elig = in_valid;
    end else if (force_bad) begin
      elig = '0;
    end else begin
      elig = in_valid & force_sel;
    end
  end

  // Scan upward from last+1, wrapping, so the previous winner has lowest priority.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(last_q) + i) % N;
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    if (win_found) begin
      win_onehot[win_idx] = 1'b1;
    end
    win_data = in_data[32'(win_idx)*W +: W];
  end

  // Register can take a new word when empty or being drained this cycle.
  assign load_en  = !out_valid_q || out_ready;
  // Gate with reset_n so no channel is accepted while reset is held.
  assign xfer     = reset_n && load_en && win_found;
  assign in_ready = xfer ? win_onehot : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_grant_d = out_grant_q;
    last_d      = last_q;
    sel_err_d   = sel_err_q | force_bad;
    if (xfer) begin
      out_data_d  = win_data;
      out_grant_d = win_onehot;
      out_valid_d = 1'b1;
      last_d      = win_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_grant_q <= '0;
      sel_err_q   <= 1'b0;
      last_q      <= IW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_grant_q <= out_grant_d;
      sel_err_q   <= sel_err_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_grant = out_grant_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed, table-driven self-checking bench for rr_mux_arb (N=4, W=16).
module tb_rr_mux_arb;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic           clk;
  logic           reset_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   force_sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_grant;
  logic           sel_err;

  int checks;
  int failures;

  rr_mux_arb #(.N(N), .W(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .force_sel(force_sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_grant(out_grant),
    .sel_err  (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] force_sel;
    logic [N-1:0] in_valid;
    logic         out_ready;
    logic [N-1:0] exp_in_ready;
    logic         exp_out_valid;
    logic [W-1:0] exp_out_data;
    logic [N-1:0] exp_out_grant;
    logic         exp_sel_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_std_data();
    for (int i = 0; i < N; i++) begin
      in_data[i*W +: W] = W'(16'h00A0 + i);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [W-1:0] ed,
                               input logic [N-1:0] eg, input logic es);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".out_data"},  32'(out_data),  32'(ed));
    chk({tag, ".out_grant"}, 32'(out_grant), 32'(eg));
    chk({tag, ".sel_err"},   32'(sel_err),   32'(es));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    force_sel = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    in_data   = '0;
    set_std_data();

    // force, valid, ordy, in_ready, ovalid, odata, ogrant, sel_err
    vecs[0]  = '{4'b0000, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'h00A0, 4'b0001, 1'b0};
    vecs[1]  = '{4'b0000, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'h00A1, 4'b0010, 1'b0};
    vecs[2]  = '{4'b0000, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'h00A2, 4'b0100, 1'b0};
    vecs[3]  = '{4'b0000, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'h00A3, 4'b1000, 1'b0};
    // last=3, only ch0/ch2 valid: 0, 2, 0
    vecs[4]  = '{4'b0000, 4'b0101, 1'b1, 4'b0001, 1'b1, 16'h00A0, 4'b0001, 1'b0};
    vecs[5]  = '{4'b0000, 4'b0101, 1'b1, 4'b0100, 1'b1, 16'h00A2, 4'b0100, 1'b0};
    vecs[6]  = '{4'b0000, 4'b0101, 1'b1, 4'b0001, 1'b1, 16'h00A0, 4'b0001, 1'b0};
    // drain with nothing valid, then idle without ready
    vecs[7]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h00A0, 4'b0001, 1'b0};
    vecs[8]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'h00A0, 4'b0001, 1'b0};
    // forced ch2 every cycle
    vecs[9]  = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'h00A2, 4'b0100, 1'b0};
    vecs[10] = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'h00A2, 4'b0100, 1'b0};
    // illegal override: no grant, drain still happens, sel_err sticks
    vecs[11] = '{4'b0110, 4'b1111, 1'b1, 4'b0000, 1'b0, 16'h00A2, 4'b0100, 1'b1};
    // forced channel not valid: nothing granted
    vecs[12] = '{4'b1000, 4'b0111, 1'b1, 4'b0000, 1'b0, 16'h00A2, 4'b0100, 1'b1};
    // back to round-robin; last=2 from forced transfer so ch3 wins
    vecs[13] = '{4'b0000, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'h00A3, 4'b1000, 1'b1};

    // Reset state
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'(0));
    check_outputs("rst", 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int v = 0; v < 14; v++) begin
      force_sel = vecs[v].force_sel;
      in_valid  = vecs[v].in_valid;
      out_ready = vecs[v].out_ready;
      #1;
      chk($sformatf("vec%0d.in_ready", v), 32'(in_ready), 32'(vecs[v].exp_in_ready));
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", v), vecs[v].exp_out_valid, vecs[v].exp_out_data,
                    vecs[v].exp_out_grant, vecs[v].exp_sel_err);
    end

    // Reset mid-stream with a held word: outputs clear before any edge
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'(0));
    check_outputs("midrst", 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Backpressure on ch2 only
    in_valid = 4'b0100;
    in_data[2*W +: W] = 16'h1234;
    out_ready = 1'b0;
    #1;
    chk("bp.accept.in_ready", 32'(in_ready), 32'(4'b0100));
    @(posedge clk);
    #1;
    check_outputs("bp.accept", 1'b1, 16'h1234, 4'b0100, 1'b0);
    in_data[2*W +: W] = 16'h5678;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp.stall%0d.in_ready", c), 32'(in_ready), 32'(0));
      @(posedge clk);
      #1;
      check_outputs($sformatf("bp.stall%0d", c), 1'b1, 16'h1234, 4'b0100, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.drain.in_ready", 32'(in_ready), 32'(4'b0100));
    @(posedge clk);
    #1;
    check_outputs("bp.drain", 1'b1, 16'h5678, 4'b0100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
# rr_mux_arb

Parametrised, registered successor to the datapath one-hot multiplexer: selects one of N valid/ready input channels of width W and forwards it through a single output register. Selection is round-robin by default, or forced to one channel by a one-hot override. It sits between multiple datapath result sources (ALU, memory, immediate, PC+k) and the register-file write-back port, where sources may stall.

## Interface
Parameters:
- N, 4, number of input channels (≥2)
- W, 16, data width per channel

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W]
- in_valid  input  N  channel i presents data
- in_ready  output  N  channel i transfer accepted this cycle (at most one bit set)
- force_sel  input  N  one-hot override; all-zero means round-robin
- out_data  output  W  registered selected data
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  downstream consumes out_data when out_valid && out_ready
- out_grant  output  N  registered one-hot index of channel that produced out_data
- sel_err  output  1  sticky flag: force_sel was non-zero and not one-hot

## Operation
- Reset (asynchronous, reset_n low): out_valid=0, out_data=0, out_grant=0, sel_err=0, rr pointer last=N-1 (channel 0 highest priority next). in_ready is combinational and is 0 while reset_n is low.
- load_en = !out_valid || out_ready (output register empty or being drained this cycle).
- Eligible set E:
  - force_sel all-zero → E = in_valid.
  - force_sel exactly one-hot → E = in_valid & force_sel.
  - force_sel otherwise → E = 0 (nothing granted); sel_err set to 1 on that clock edge and held until reset.
- Round-robin: winner is the first set bit of E scanning upward from (last+1) mod N, wrapping at N-1→0. In forced mode the winner is the forced channel if it is valid.
- in_ready[winner] = load_en && E != 0; all other in_ready bits are 0. in_ready never depends on in_valid of the same channel except through E (no combinational out_ready→in_ready path beyond load_en).
- On a transfer (any in_ready & in_valid): out_data ← winner's data, out_grant ← one-hot(winner), out_valid ← 1, last ← winner.
- No transfer, out_valid && out_ready: out_valid ← 0; out_data, out_grant hold.
- No transfer, out_valid && !out_ready: all outputs hold (stall; data stable).
- The pointer updates only on an accepted transfer, including forced transfers.

## Timing
- Latency: 1 cycle from accepted input (edge k) to out_valid/out_data (after edge k).
- Throughput: 1 word/cycle when out_ready is held high; simultaneous drain and load in the same cycle allowed with no bubble.
- Fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,… ; no channel waits more than N-1 transfers.
- Simultaneous events: force_sel changes take effect in the same cycle (combinational); an illegal force_sel in a cycle blocks that cycle's transfer even if out_ready=1, but draining still occurs.
- Reset mid-stream: a word held in the output register is discarded; no in_ready is asserted during reset or on the first edge's evaluation after release until load_en is evaluated from reset state (out_valid=0 ⇒ first cycle after release may accept).

## Test plan
- Reset: reset_n low mid-transfer with out_valid=1 → out_valid=0, out_grant=0, out_data=0, sel_err=0 immediately (before next edge); in_ready=0.
- Round-robin, N=4, W=16: all in_valid=1, in_data ch i = 16'hA0+i, out_ready=1 → out_data sequence A0,A1,A2,A3,A0 on consecutive cycles, out_grant 0001,0010,0100,1000,0001.
- Backpressure: only ch2 valid (16'h1234), out_ready=0 for 3 cycles → out_valid=1, out_data=1234 stable, in_ready=0 after first accept; raising out_ready drains and accepts next ch2 word same cycle.
- Skipping/wrap: last=ch3, in_valid=0101 → next grant ch0, then ch2, then ch0.
- Force mode: force_sel=0100, all valid → only ch2 granted every cycle; force_sel=0110 → no in_ready, sel_err=1 on next edge and remains 1 after force_sel returns to 0000.
